// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: ALU codes, opcodes,
// FSM state encoding and trap causes.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND    = 4'b0000,
    ALU_OR     = 4'b0001,
    ALU_ADD    = 4'b0010,
    ALU_SLL    = 4'b0011,
    ALU_SUB    = 4'b0100,
    ALU_SRL    = 4'b0101,
    ALU_SRA    = 4'b0110,
    ALU_XOR    = 4'b0111,
    ALU_SLT    = 4'b1000,
    ALU_SLTU   = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_RD   = 3'd2,
    ST_DECODE    = 3'd3,
    ST_EXECUTE   = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: maps the instruction register onto ALU
// control, operand select, immediate, register fields and an illegal flag.
module instr_decode (
  input  logic [31:0] ir,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src_imm,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        illegal
);
  import core_ctrl_pkg::*;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign rd     = ir[11:7];

  always_comb begin
    alu_ctrl    = ALU_ADD;
    alu_src_imm = 1'b0;
    imm         = 32'd0;
    illegal     = 1'b0;
    case (opcode)
      OP_R: begin
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: alu_ctrl = ALU_ADD;
          {F7_BASE, 3'b001}: alu_ctrl = ALU_SLL;
          {F7_BASE, 3'b010}: alu_ctrl = ALU_SLT;
          {F7_BASE, 3'b011}: alu_ctrl = ALU_SLTU;
          {F7_BASE, 3'b100}: alu_ctrl = ALU_XOR;
          {F7_BASE, 3'b101}: alu_ctrl = ALU_SRL;
          {F7_BASE, 3'b110}: alu_ctrl = ALU_OR;
          {F7_BASE, 3'b111}: alu_ctrl = ALU_AND;
          {F7_ALT,  3'b000}: alu_ctrl = ALU_SUB;
          {F7_ALT,  3'b101}: alu_ctrl = ALU_SRA;
          default:           illegal  = 1'b1;
        endcase
      end
      OP_I: begin
        alu_src_imm = 1'b1;
        imm         = {{20{ir[31]}}, ir[31:20]};
        // Shift-immediates reuse the upper immediate bits as a funct7 qualifier.
        case (funct3)
          3'b000: alu_ctrl = ALU_ADD;
          3'b010: alu_ctrl = ALU_SLT;
          3'b011: alu_ctrl = ALU_SLTU;
          3'b100: alu_ctrl = ALU_XOR;
          3'b110: alu_ctrl = ALU_OR;
          3'b111: alu_ctrl = ALU_AND;
          3'b001: begin
            if (funct7 == F7_BASE) alu_ctrl = ALU_SLL;
            else                   illegal  = 1'b1;
          end
          default: begin
            if (funct7 == F7_BASE)     alu_ctrl = ALU_SRL;
            else if (funct7 == F7_ALT) alu_ctrl = ALU_SRA;
            else                       illegal  = 1'b1;
          end
        endcase
      end
      OP_LUI: begin
        alu_ctrl    = ALU_PASS_B;
        alu_src_imm = 1'b1;
        imm         = {ir[31:12], 12'd0};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch handshake, decode, execute and
// writeback sequencing with illegal-instruction and fetch-timeout traps.
module multicycle_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TIMEOUT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src_imm,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [31:0] imm,
  output logic        reg_write,
  output logic        pc_inc,
  output logic        retire,
  output logic        busy,
  output logic        trap,
  output logic [1:0]  trap_cause
);
  import core_ctrl_pkg::*;

  state_e               state, next_state;
  logic [31:0]          ir;
  logic [TIMEOUT_W-1:0] tcount;
  logic                 timeout_hit;
  logic                 fetch_done;

  logic [3:0]  dec_alu_ctrl;
  logic        dec_alu_src_imm;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_illegal;

  instr_decode u_decode (
    .ir          (ir),
    .alu_ctrl    (dec_alu_ctrl),
    .alu_src_imm (dec_alu_src_imm),
    .imm         (dec_imm),
    .rs1         (dec_rs1),
    .rs2         (dec_rs2),
    .rd          (dec_rd),
    .illegal     (dec_illegal)
  );

  assign timeout_hit = (tcount == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  assign fetch_done  = ((state == ST_FETCH) && imem_gnt && imem_rvalid) ||
                       ((state == ST_WAIT_RD) && imem_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // A same-cycle gnt+rvalid skips WAIT_RD; rvalid on the last allowed cycle beats the timeout.
  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    reg_write  = 1'b0;
    pc_inc     = 1'b0;
    retire     = 1'b0;
    busy       = 1'b1;
    trap       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (run) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_gnt && imem_rvalid) next_state = ST_DECODE;
        else if (timeout_hit)        next_state = ST_TRAP;
        else if (imem_gnt)           next_state = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (imem_rvalid)      next_state = ST_DECODE;
        else if (timeout_hit) next_state = ST_TRAP;
      end
      ST_DECODE:  next_state = dec_illegal ? ST_TRAP : ST_EXECUTE;
      ST_EXECUTE: next_state = ST_WRITEBACK;
      ST_WRITEBACK: begin
        reg_write  = (rd_addr != 5'd0);
        pc_inc     = 1'b1;
        retire     = 1'b1;
        next_state = run ? ST_FETCH : ST_IDLE;
      end
      ST_TRAP: begin
        busy = 1'b0;
        trap = 1'b1;
        if (!run) next_state = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir     <= 32'd0;
      tcount <= '0;
    end else begin
      if (fetch_done) ir <= imem_rdata;
      if (next_state == ST_FETCH && state != ST_FETCH)
        tcount <= '0;
      else if (state == ST_FETCH || state == ST_WAIT_RD)
        tcount <= tcount + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_cause <= CAUSE_NONE;
    end else if (next_state == ST_TRAP && state != ST_TRAP) begin
      trap_cause <= (state == ST_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
    end else if (state == ST_TRAP && next_state == ST_IDLE) begin
      trap_cause <= CAUSE_NONE;
    end
  end

  // Decode results are captured once in DECODE and held until the next DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl    <= 4'd0;
      alu_src_imm <= 1'b0;
      imm         <= 32'd0;
      rs1_addr    <= 5'd0;
      rs2_addr    <= 5'd0;
      rd_addr     <= 5'd0;
    end else if (state == ST_DECODE) begin
      alu_ctrl    <= dec_alu_ctrl;
      alu_src_imm <= dec_alu_src_imm;
      imm         <= dec_imm;
      rs1_addr    <= dec_rs1;
      rs2_addr    <= dec_rs2;
      rd_addr     <= dec_rd;
    end
  end

endmodule
